cp0_int_ctrl: RTL and testbench
===============================

Name: cp0_int_ctrl

Overview:
- Interrupt and exception controller (Coprocessor 0) for the pipelined CPU; the receiving end of the peripheral IRQ lines driven by the timers and the external interrupt generator.
- Samples the hardware interrupt lines every cycle, combines them with pipeline-reported exceptions and raises a single request to flush the pipeline and redirect to the handler.
- Holds the SR, Cause and EPC registers, which are accessed by mfc0/mtc0 and cleared on eret.

Parameters:
- PRID_VALUE, 32'h0000_2024, PRId constant; used only when CP0_PRID_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- A  in  5  CP0 register number for read and write
- WE  in  1  mtc0 write enable, applied at the next clk edge
- Din  in  32  mtc0 write data
- Dout  out  32  combinational read data for register A
- VPC  in  32  PC of the instruction currently at the macro-PC (M) stage
- BDIn  in  1  that instruction sits in a branch delay slot
- ExcCodeIn  in  5  exception code reported by the pipeline; 0 means no exception
- HWInt  in  6  hardware interrupt lines: [0] timer 0, [1] timer 1, [2] external interrupt generator, [5:3] tied 0
- EXLClr  in  1  eret at the M stage
- EPCOut  out  32  current EPC value
- Req  out  1  exception or interrupt taken this cycle

Behaviour:
- Register numbers:
  - SR = 12: IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause = 13: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC = 14.
  - Any other number reads 0.
- Reset (asynchronous): SR = 0, Cause = 0, EPC = 0. Req and Dout follow combinationally, so Req = 0 during reset.
- IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- ExcReq = (ExcCodeIn != 0) & ~SR.EXL.
- Req = IntReq | ExcReq (combinational, same cycle).
- Cause.IP is updated with HWInt on every edge, independent of Req. It reflects HWInt one cycle late.
- On an edge with Req = 1:
  - SR.EXL <= 1.
  - Cause.BD <= BDIn.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn. The interrupt has priority when both requests are present.
  - EPC <= (BDIn ? VPC - 4 : VPC) with bits [1:0] forced to 0.
- mtc0 (WE = 1 and Req = 0):
  - SR: only IM, EXL and IE are written.
  - EPC: written with Din[31:2], bits [1:0] forced to 0.
  - Cause and unknown numbers: write ignored.
- Simultaneous events:
  - Req with WE: Req wins and the write is dropped, because that instruction is being flushed.
  - EXLClr with WE to SR: EXLClr wins for EXL; IM and IE are still written.
  - EXLClr with Req: not reachable, since EXL = 1 blocks Req. EXLClr alone sets EXL <= 0.
- Level-sensitive: a timer IRQ held high re-requests immediately after eret if IE and IM are still set. No internal edge latching is done.
- Read-during-write: Dout shows the old value until the edge (no bypass). The pipeline forwards.

Optional Feature:
- Macro: CP0_PRID_EN.
- Defined: register 15 (PRId) reads PRID_VALUE; writes to it are ignored.
- Undefined: register 15 reads 0 and is not implemented.

Decomposition:
- Shared package/macros file holds:
  - Register numbers: SR 12, CAUSE 13, EPC 14, PRID 15.
  - ExcCode constants: Int 0, AdEL 4, AdES 5, Syscall 8, RI 10, Ov 12.
  - SR/Cause field bit positions.
- No sub-module is needed. Request arbitration stays inline (about 150 lines).

Test Plan:
- Reset: assert reset mid-cycle → Dout for A = 12/13/14 reads 0 at once, Req = 0.
- Timer interrupt: write SR = 32'h0000_0401, hold HWInt = 6'b000001, VPC = 32'h0000_3010 →
  - Req = 1 the same cycle.
  - After the edge: EPC = 32'h3010, Cause.ExcCode = 0, SR.EXL = 1, Req = 0.
- Delay-slot exception: ExcCodeIn = 12, BDIn = 1, VPC = 32'h3024, SR.EXL = 0 →
  - EPC = 32'h3020, Cause = 32'h8000_0030 (with IP = 0).
- Priority: HWInt[1] = 1 unmasked together with ExcCodeIn = 10 → Cause.ExcCode = 0, EPC = VPC.
- Masking and eret:
  - HWInt = 6'b000100 with IM = 6'b000001 → Req = 0, while Cause.IP[12] becomes 1 next cycle.
  - Pulse EXLClr while EXL = 1 → EXL = 0, and Req rises if an unmasked line is high.
- Write conflict and PRId:
  - WE to EPC (Din = 32'h3047) on the same edge as Req → EPC takes the exception value; with no Req it reads 32'h3044.
  - With CP0_PRID_EN, A = 15 reads PRID_VALUE.

Source files
------------

// File: rtl/cp0_int_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, SR/Cause field positions
// and helpers that assemble the architectural SR and Cause words.
package cp0_int_ctrl_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LO      = 10;
    localparam int SR_IM_HI      = 15;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_IP_LO   = 10;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_BD_BIT  = 31;

    function automatic logic [31:0] pack_sr(
        input logic [5:0] im,
        input logic       exl,
        input logic       ie
    );
        logic [31:0] v;
        v = 32'd0;
        v[SR_IM_HI:SR_IM_LO] = im;
        v[SR_EXL_BIT]        = exl;
        v[SR_IE_BIT]         = ie;
        return v;
    endfunction

    function automatic logic [31:0] pack_cause(
        input logic       bd,
        input logic [5:0] ip,
        input logic [4:0] exc
    );
        logic [31:0] v;
        v = 32'd0;
        v[CAUSE_BD_BIT]              = bd;
        v[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
        v[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc;
        return v;
    endfunction

endpackage

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt/exception controller: SR, Cause, EPC, request arbitration.
// Optional macro CP0_PRID_EN adds a read-only PRId register at number 15.
module cp0_int_ctrl
    import cp0_int_ctrl_pkg::*;
`ifdef CP0_PRID_EN
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_2024
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic        w_wr_sr;
    logic        w_wr_epc;
    logic [31:0] w_epc_target;
    logic [31:0] w_dout;

    // Interrupts need IE and no EXL; exceptions only need EXL clear.
    assign w_int_req = (|(HWInt & r_sr_im)) & r_sr_ie & ~r_sr_exl;
    assign w_exc_req = (ExcCodeIn != EXC_INT) & ~r_sr_exl;
    assign w_req     = w_int_req | w_exc_req;

    // A taken request flushes the mtc0 in flight, so its write is dropped.
    assign w_wr_sr  = WE & ~w_req & (A == REG_SR);
    assign w_wr_epc = WE & ~w_req & (A == REG_EPC);

    assign w_epc_target = (BDIn ? (VPC - 32'd4) : VPC) & 32'hFFFF_FFFC;

    // Read mux over the implemented registers.
    always_comb begin
        w_dout = 32'd0;
        case (A)
            REG_SR:    w_dout = pack_sr(r_sr_im, r_sr_exl, r_sr_ie);
            REG_CAUSE: w_dout = pack_cause(r_cause_bd, r_cause_ip, r_cause_exc);
            REG_EPC:   w_dout = r_epc;
`ifdef CP0_PRID_EN
            REG_PRID:  w_dout = PRID_VALUE;
`endif
            default:   w_dout = 32'd0;
        endcase
    end

    // SR: EXL set on request; eret clears EXL even when SR is written the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr_im  <= 6'd0;
            r_sr_exl <= 1'b0;
            r_sr_ie  <= 1'b0;
        end else if (w_req) begin
            r_sr_exl <= 1'b1;
        end else if (w_wr_sr) begin
            r_sr_im  <= Din[SR_IM_HI:SR_IM_LO];
            r_sr_ie  <= Din[SR_IE_BIT];
            r_sr_exl <= Din[SR_EXL_BIT] & ~EXLClr;
        end else if (EXLClr) begin
            r_sr_exl <= 1'b0;
        end
    end

    // Cause: IP tracks the lines every edge; BD/ExcCode captured on request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= 6'd0;
            r_cause_exc <= 5'd0;
        end else begin
            r_cause_ip <= HWInt;
            if (w_req) begin
                r_cause_bd  <= BDIn;
                r_cause_exc <= w_int_req ? EXC_INT : ExcCodeIn;
            end
        end
    end

    // EPC: restart address on request, otherwise word-aligned mtc0 data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_epc <= 32'd0;
        end else if (w_req) begin
            r_epc <= w_epc_target;
        end else if (w_wr_epc) begin
            r_epc <= {Din[31:2], 2'b00};
        end
    end

    assign Dout   = w_dout;
    assign EPCOut = r_epc;
    assign Req    = w_req;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Self-checking bench for cp0_int_ctrl: directed scenarios plus random traffic
// compared every cycle against a word-level model of SR/Cause/EPC.
module tb_cp0_int_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  A;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    logic [31:0] m_sr, m_cause, m_epc;

    cp0_int_ctrl dut (
        .clk(clk), .reset(reset), .A(A), .WE(WE), .Din(Din), .Dout(Dout),
        .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] prid_exp();
`ifdef CP0_PRID_EN
        return 32'h0000_2024;
`else
        return 32'h0000_0000;
`endif
    endfunction

    function automatic logic m_int();
        return (|(HWInt & m_sr[15:10])) & m_sr[0] & ~m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int() | ((ExcCodeIn != 5'd0) & ~m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return prid_exp();
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: architectural words updated from the register rules.
    always @(posedge clk or posedge reset) begin : model
        logic [31:0] n_sr, n_cause, n_epc;
        if (reset) begin
            m_sr    <= 32'd0;
            m_cause <= 32'd0;
            m_epc   <= 32'd0;
        end else begin
            n_sr    = m_sr;
            n_cause = m_cause;
            n_epc   = m_epc;
            if (m_req()) begin
                n_sr[1]      = 1'b1;
                n_cause[31]  = BDIn;
                n_cause[6:2] = m_int() ? 5'd0 : ExcCodeIn;
                n_epc        = (BDIn ? VPC - 32'd4 : VPC) & ~32'd3;
            end else begin
                if (WE && A == 5'd12) n_sr = Din & 32'h0000_FC03;
                if (WE && A == 5'd14) n_epc = Din & ~32'd3;
                if (EXLClr) n_sr[1] = 1'b0;
            end
            n_cause[15:10] = HWInt;
            m_sr    <= n_sr;
            m_cause <= n_cause;
            m_epc   <= n_epc;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        #3;
        if (chk_en && !reset) begin
            chk("req", {31'd0, Req}, {31'd0, m_req()});
            chk("dout", Dout, m_read(A));
            chk("epcout", EPCOut, m_epc);
        end
    end

    task automatic cyc(input logic [4:0] a, input logic we, input logic [31:0] din,
                       input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                       input logic [5:0] hw, input logic clr);
        @(negedge clk);
        #1;
        A = a; WE = we; Din = din; VPC = vpc; BDIn = bd;
        ExcCodeIn = exc; HWInt = hw; EXLClr = clr;
    endtask

    task automatic idle(input logic [4:0] a, input logic [5:0] hw);
        cyc(a, 1'b0, 32'd0, 32'h0000_1000, 1'b0, 5'd0, hw, 1'b0);
    endtask

    initial begin
        logic [4:0] excs [5];
        excs[0] = 5'd4; excs[1] = 5'd5; excs[2] = 5'd8; excs[3] = 5'd10; excs[4] = 5'd12;
        reset = 1'b1;
        A = 5'd0; WE = 1'b0; Din = 32'd0; VPC = 32'd0; BDIn = 1'b0;
        ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // timer interrupt
        cyc(5'd12, 1'b1, 32'h0000_0401, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        cyc(5'd14, 1'b0, 32'h0, 32'h0000_3010, 1'b0, 5'd0, 6'b000001, 1'b0);
        #4 chk("timer_req", {31'd0, Req}, 32'd1);
        idle(5'd12, 6'b000001);
        #4 chk("timer_epc", EPCOut, 32'h0000_3010);
        chk("timer_sr", Dout, 32'h0000_0403);
        chk("timer_req_after", {31'd0, Req}, 32'd0);
        A = 5'd13; #1 chk("timer_cause", Dout, 32'h0000_0400);

        // asynchronous reset mid-cycle
        idle(5'd12, 6'b000001);
        #4 reset = 1'b1;
        #1 chk("rst_sr", Dout, 32'd0);
        chk("rst_req", {31'd0, Req}, 32'd0);
        A = 5'd13; #1 chk("rst_cause", Dout, 32'd0);
        A = 5'd14; #1 chk("rst_epc", Dout, 32'd0);
        @(negedge clk); #1 reset = 1'b0;

        // delay-slot overflow exception
        cyc(5'd0, 1'b0, 32'h0, 32'h0000_3024, 1'b1, 5'd12, 6'd0, 1'b0);
        #4 chk("ds_req", {31'd0, Req}, 32'd1);
        idle(5'd13, 6'd0);
        #4 chk("ds_cause", Dout, 32'h8000_0030);
        chk("ds_epc", EPCOut, 32'h0000_3020);

        // interrupt beats simultaneous exception
        cyc(5'd12, 1'b1, 32'h0000_0801, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        cyc(5'd0, 1'b0, 32'h0, 32'h0000_3100, 1'b0, 5'd10, 6'b000010, 1'b0);
        #4 chk("prio_req", {31'd0, Req}, 32'd1);
        idle(5'd13, 6'd0);
        #4 chk("prio_cause", Dout, 32'h0000_0800);
        chk("prio_epc", EPCOut, 32'h0000_3100);

        // masked line still shows in IP
        cyc(5'd12, 1'b1, 32'h0000_0401, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        idle(5'd13, 6'b000100);
        #4 chk("mask_req", {31'd0, Req}, 32'd0);
        idle(5'd13, 6'b000100);
        #4 chk("mask_ip", Dout, 32'h0000_1000);
        chk("mask_req2", {31'd0, Req}, 32'd0);

        // eret re-enables a held line; request beats a concurrent EPC write
        cyc(5'd12, 1'b1, 32'h0000_0403, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        idle(5'd12, 6'b000001);
        #4 chk("exl_block", {31'd0, Req}, 32'd0);
        cyc(5'd12, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 6'b000001, 1'b1);
        cyc(5'd14, 1'b1, 32'h0000_3047, 32'h0000_3200, 1'b0, 5'd0, 6'b000001, 1'b0);
        #4 chk("eret_rereq", {31'd0, Req}, 32'd1);
        chk("no_bypass", Dout, 32'h0000_3100);
        idle(5'd12, 6'd0);
        #4 chk("conflict_epc", EPCOut, 32'h0000_3200);
        chk("conflict_sr", Dout, 32'h0000_0403);

        // eret together with an SR write
        cyc(5'd12, 1'b1, 32'h0000_8403, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
        idle(5'd12, 6'd0);
        #4 chk("clr_we_sr", Dout, 32'h0000_8401);

        // plain EPC write, PRId and unknown register
        cyc(5'd14, 1'b1, 32'h0000_3047, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        #4 chk("epc_wr_noreq", {31'd0, Req}, 32'd0);
        idle(5'd14, 6'd0);
        #4 chk("epc_wr", Dout, 32'h0000_3044);
        chk("epc_out", EPCOut, 32'h0000_3044);
        cyc(5'd15, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        idle(5'd15, 6'd0);
        #4 chk("prid", Dout, prid_exp());
        A = 5'd3; #1 chk("unknown_reg", Dout, 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0]  ra;
            logic [31:0] rdin;
            int sel;
            sel = $urandom_range(0, 7);
            ra = (sel < 4) ? (5'd12 + 5'(sel)) : 5'($urandom_range(0, 31));
            rdin = $urandom;
            cyc(ra, ($urandom_range(0, 2) == 0), rdin, $urandom, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0) ? excs[$urandom_range(0, 4)] : 5'd0,
                {3'b000, 3'($urandom_range(0, 7))}, ($urandom_range(0, 7) == 0));
            if (i == 1500) begin
                #4 reset = 1'b1;
                @(negedge clk); #1 reset = 1'b0;
            end
        end

        @(negedge clk);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
